// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared state encodings and forwarding select codes
package pipeline_hazard_controller_pkg;
    typedef logic [1:0] fwd_sel_t;
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] ANNUL = 2'd2;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: pipeline stage fields in, stage control and forwarding selects out
interface pipeline_hazard_controller_if
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ID_rs1, ID_rs2, ID_rd;
    logic             ID_use_rs1, ID_use_rs2, ID_use_rd;
    logic [REG_W-1:0] EX_RD_instr, MEM_RD_instr, WB_RD_instr;
    logic             EX_rf_en, MEM_rf_en, WB_rf_en;
    logic             EX_load, ID_annul;
    logic             PC_LE, IF_ID_LE, ID_EX_clr, ID_squash;
    fwd_sel_t         fwd_rs1, fwd_rs2, fwd_rd;
    logic [CNT_W-1:0] stall_cnt, annul_cnt;
    modport master (
        output ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2, ID_use_rd,
        output EX_RD_instr, MEM_RD_instr, WB_RD_instr, EX_rf_en, MEM_rf_en, WB_rf_en,
        output EX_load, ID_annul,
        input  PC_LE, IF_ID_LE, ID_EX_clr, ID_squash, fwd_rs1, fwd_rs2, fwd_rd,
        input  stall_cnt, annul_cnt
    );
    modport slave (
        input  ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2, ID_use_rd,
        input  EX_RD_instr, MEM_RD_instr, WB_RD_instr, EX_rf_en, MEM_rf_en, WB_rf_en,
        input  EX_load, ID_annul,
        output PC_LE, IF_ID_LE, ID_EX_clr, ID_squash, fwd_rs1, fwd_rs2, fwd_rd,
        output stall_cnt, annul_cnt
    );
endinterface

// File: rtl/pipeline_hazard_controller_forward_select.sv
// forward_select: EX > MEM > WB priority forwarding compare for one ID source field
module forward_select
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_en,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_en,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_en,
    output fwd_sel_t         sel,
    output logic             ex_hit
);
    logic live;
    always_comb begin
        live   = use_src && src != '0;
        ex_hit = live && ex_en && ex_rd == src;
        // a load's data is not ready out of EX, so fall through to older stages
        sel    = (ex_hit && !ex_load)           ? FWD_EX  :
                 (live && mem_en && mem_rd == src) ? FWD_MEM :
                 (live && wb_en && wb_rd == src)   ? FWD_WB  : FWD_RF;
    end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, delay-slot annul and operand forwarding control
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_controller_if.slave h
);
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, annul_cnt_q, annul_cnt_d;
    logic [2:0]       ex_hit;
    logic             run_stall, in_annul;

    forward_select #(.REG_W(REG_W)) u_rs1 (
        .src(h.ID_rs1), .use_src(h.ID_use_rs1),
        .ex_rd(h.EX_RD_instr), .ex_en(h.EX_rf_en), .ex_load(h.EX_load),
        .mem_rd(h.MEM_RD_instr), .mem_en(h.MEM_rf_en),
        .wb_rd(h.WB_RD_instr), .wb_en(h.WB_rf_en),
        .sel(h.fwd_rs1), .ex_hit(ex_hit[0])
    );
    forward_select #(.REG_W(REG_W)) u_rs2 (
        .src(h.ID_rs2), .use_src(h.ID_use_rs2),
        .ex_rd(h.EX_RD_instr), .ex_en(h.EX_rf_en), .ex_load(h.EX_load),
        .mem_rd(h.MEM_RD_instr), .mem_en(h.MEM_rf_en),
        .wb_rd(h.WB_RD_instr), .wb_en(h.WB_rf_en),
        .sel(h.fwd_rs2), .ex_hit(ex_hit[1])
    );
    forward_select #(.REG_W(REG_W)) u_rd (
        .src(h.ID_rd), .use_src(h.ID_use_rd),
        .ex_rd(h.EX_RD_instr), .ex_en(h.EX_rf_en), .ex_load(h.EX_load),
        .mem_rd(h.MEM_RD_instr), .mem_en(h.MEM_rf_en),
        .wb_rd(h.WB_RD_instr), .wb_en(h.WB_rf_en),
        .sel(h.fwd_rd), .ex_hit(ex_hit[2])
    );

    always_comb begin
        in_annul    = state_q == ANNUL;
        run_stall   = state_q == RUN && h.EX_load && |ex_hit;
        // stall beats annul; a held branch takes its annul from STALL
        state_d     = in_annul ? RUN : run_stall ? STALL : h.ID_annul ? ANNUL : RUN;
        stall_cnt_d = stall_cnt_q + CNT_W'(run_stall && !(&stall_cnt_q));
        annul_cnt_d = annul_cnt_q + CNT_W'(in_annul && !(&annul_cnt_q));
    end

    assign h.PC_LE     = !run_stall;
    assign h.IF_ID_LE  = !run_stall;
    assign h.ID_EX_clr = run_stall || in_annul;
    assign h.ID_squash = in_annul;
    assign h.stall_cnt = stall_cnt_q;
    assign h.annul_cnt = annul_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            annul_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            annul_cnt_q <= annul_cnt_d;
        end
    end
endmodule
